hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W).
- Consumes the per-instruction Tuse_rs, Tuse_rt and Tnew codes produced by the decode control unit.
- Tracks in-flight writers in E/M/W, generates the D-stage stall, and produces D-stage and E-stage forwarding selects.
- Sequences the multi-cycle mult/div unit busy window, stalling HI/LO users until it clears.

Parameters:
- MD_LAT, 5, mult/div busy cycles after a start instruction enters E (legal range 1..15).
- TMAX, 15, Tuse code meaning "operand never read"; Tnew code for non-writers is 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_valid  in  1  D holds a real instruction (0 = bubble).
- d_rs  in  5  D-stage rs index.
- d_rt  in  5  D-stage rt index.
- d_wa  in  5  D-stage destination register; 0 = no write.
- d_tuse_rs  in  4  cycles after D until rs is consumed.
- d_tuse_rt  in  4  cycles after D until rt is consumed.
- d_tnew  in  4  cycles after D until the result exists.
- d_md_start  in  1  D instruction is mult/multu/div/divu.
- d_md_use  in  1  D instruction reads/writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- stall  out  1  freeze PC and F/D register; insert bubble into E.
- fwd_d_rs  out  2  D rs source: 0 regfile, 1 E, 2 M, 3 W.
- fwd_d_rt  out  2  same encoding for rt.
- fwd_e_rs  out  2  E rs source: 0 pipeline reg, 1 M, 2 W.
- fwd_e_rt  out  2  same encoding for rt.
- md_busy  out  1  mult/div unit busy.

Behaviour:
- State is held in stage records E, M, W, each {wa[4:0], tnew[3:0]}; E additionally holds {rs, rt, md_start}. There is also a 4-bit md_cnt.
- Reset (reset=0, async): all records cleared (wa=0, tnew=0, rs=rt=0, md_start=0) and md_cnt=0. Consequently stall=0, all fwd_*=0, md_busy=0 while in reset and in the first cycle after reset.
- Stage advance, every rising clk edge:
  - E <= (d_valid && !stall) ? {d_wa, sat(d_tnew-1), d_rs, d_rt, d_md_start} : bubble (all zero).
  - M <= {E.wa, sat(E.tnew-1)}.
  - W <= {M.wa, sat(M.tnew-1)}.
  - sat(x-1) saturates at 0; there is no wrap-around from 0 to 15.
- Match rule: X matches reg r iff X.wa == r and r != 0. Register 0 never matches, stalls or forwards.
- Stall, combinational, applies only when d_valid=1:
  - stall_rs = d_tuse_rs != TMAX and (E matches d_rs with E.tnew > d_tuse_rs, or M matches d_rs with M.tnew > d_tuse_rs).
  - stall_rt is the same using d_rt and d_tuse_rt.
  - stall_md = d_md_use and (md_busy or E.md_start).
  - stall = stall_rs | stall_rt | stall_md.
- D forwarding selects: take the youngest matching stage whose tnew==0, priority E > M > W.
  - If the youngest matching stage has tnew != 0, fwd = 0; the stall covers it when its Tuse requires.
  - A W match always has tnew==0.
- E forwarding selects for E.rs and E.rt: 1 if M matches with M.tnew==0; else 2 if W matches; else 0.
- Mult/div counter:
  - If E.md_start: md_cnt <= MD_LAT.
  - Else if md_cnt != 0: md_cnt <= md_cnt-1.
  - md_busy = (md_cnt != 0).
  - A start in E while md_cnt != 0 reloads MD_LAT. This is legal only because stall_md prevents it; the verifier asserts it never occurs.
- Simultaneous events:
  - A stalled D instruction does not enter E and its md_start is not recorded.
  - Stall and a W-stage write in the same cycle: W still forwards.
  - Stall is re-evaluated every cycle with no hysteresis. It deasserts in the same cycle the condition clears, so a lw→use sequence costs exactly 1 bubble.
- Tnew conventions from decode:
  - calc_R/calc_I/shift/jal = 2, lw = 3, store/branch/jr = 0.
  - Tuse: 0 branch/jr, 1 ALU/store, TMAX unused.
- Reset asserted mid-operation clears the in-flight scoreboard and md_cnt immediately. No stall survives reset.

Test Plan:
- Reset then idle: reset low 3 cycles, release, d_valid=0 → stall=0, all fwd=0, md_busy=0 for 10 cycles.
- Load-use: cycle0 D lw (wa=8, tnew=3); cycle1 D add (rs=8, tuse_rs=1).
  - Required: stall=1 exactly 1 cycle (E.tnew=2>1).
  - Then the add proceeds with fwd_d_rs=0, and next cycle fwd_e_rs=2 (lw in W).
- Branch after ALU: add wa=9 then beq rs=9 (tuse=0).
  - Required: stall 1 cycle (E.tnew=1>0), then fwd_d_rs=2 (M, tnew 0), no further stall.
- $0 and priority: add wa=0 then sub rs=0 → no stall, fwd_d_rs=0.
  - Two writers wa=5 in E (tnew 0 via jal→store path) and M: fwd_d_rs=1.
- Mult/div: mult in D, then mflo next (d_md_use=1), MD_LAT=5.
  - Required: stall 6 cycles (E.md_start plus 5 busy), md_busy high 5 cycles, mflo issues on 7th cycle.
- Reset mid-stall: assert reset during the mult/div stall window → md_busy and stall drop asynchronously within the same cycle; after release, mflo issues without stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W).
// Keeps a small scoreboard of in-flight writers in E/M/W, decides the D-stage
// stall, produces D- and E-stage forwarding selects, and times the
// multi-cycle mult/div busy window so HI/LO users wait until it clears.
//
// Handshake: there is no valid/ready pair here. d_valid qualifies the D-stage
// instruction. stall=1 means "D is not accepted this cycle". The upstream
// pipeline holds PC and the F/D register, and this block loads a bubble into
// its E record instead of the D instruction.
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 5,
  parameter int unsigned TMAX   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_wa,
  input  logic [3:0] d_tuse_rs,
  input  logic [3:0] d_tuse_rt,
  input  logic [3:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       md_busy
);

  localparam logic [3:0] L_TMAX   = 4'(TMAX);
  localparam logic [3:0] L_MD_LAT = 4'(MD_LAT);

  // Stage records
  logic [4:0] r_e_wa;
  logic [3:0] r_e_tnew;
  logic [4:0] r_e_rs;
  logic [4:0] r_e_rt;
  logic       r_e_md_start;
  logic [4:0] r_m_wa;
  logic [3:0] r_m_tnew;
  logic [4:0] r_w_wa;
  logic [3:0] r_w_tnew;
  logic [3:0] r_md_cnt;

  logic       w_stall_rs;
  logic       w_stall_rt;
  logic       w_stall_md;
  logic       w_issue;

  // Countdown toward "result exists", pinned at zero (never wraps to 15).
  function automatic logic [3:0] sat_dec(input logic [3:0] x);
    return (x == 4'd0) ? 4'd0 : x - 4'd1;
  endfunction

  // A stage supplies register r only when it writes r and r is not $0.
  function automatic logic reg_match(input logic [4:0] wa, input logic [4:0] r);
    return (r != 5'd0) && (wa == r);
  endfunction

  // D-stage source pick: the youngest matching stage wins; if its value is
  // not ready yet, read the regfile (the stall logic covers the real hazard).
  function automatic logic [1:0] d_src(
    input logic [4:0] r,
    input logic [4:0] e_wa, input logic [3:0] e_tnew,
    input logic [4:0] m_wa, input logic [3:0] m_tnew,
    input logic [4:0] w_wa, input logic [3:0] w_tnew
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (reg_match(e_wa, r))      sel = (e_tnew == 4'd0) ? 2'd1 : 2'd0;
    else if (reg_match(m_wa, r)) sel = (m_tnew == 4'd0) ? 2'd2 : 2'd0;
    else if (reg_match(w_wa, r)) sel = (w_tnew == 4'd0) ? 2'd3 : 2'd0;
    return sel;
  endfunction

  // E-stage source pick: a ready M result beats W, else pipeline register.
  function automatic logic [1:0] e_src(
    input logic [4:0] r,
    input logic [4:0] m_wa, input logic [3:0] m_tnew,
    input logic [4:0] w_wa
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (reg_match(m_wa, r) && (m_tnew == 4'd0)) sel = 2'd1;
    else if (reg_match(w_wa, r))                 sel = 2'd2;
    return sel;
  endfunction

  // Operand hazards: a producer in E or M that will not be ready by the time
  // D's operand is consumed. TMAX means the operand is never read.
  assign w_stall_rs = (d_tuse_rs != L_TMAX) &&
                      ((reg_match(r_e_wa, d_rs) && (r_e_tnew > d_tuse_rs)) ||
                       (reg_match(r_m_wa, d_rs) && (r_m_tnew > d_tuse_rs)));
  assign w_stall_rt = (d_tuse_rt != L_TMAX) &&
                      ((reg_match(r_e_wa, d_rt) && (r_e_tnew > d_tuse_rt)) ||
                       (reg_match(r_m_wa, d_rt) && (r_m_tnew > d_tuse_rt)));
  // HI/LO users wait while the unit counts down, and also in the cycle the
  // start sits in E (the counter has not been loaded yet).
  assign w_stall_md = d_md_use && (md_busy || r_e_md_start);

  assign md_busy = (r_md_cnt != 4'd0);
  assign stall   = d_valid && (w_stall_rs || w_stall_rt || w_stall_md);
  assign w_issue = d_valid && !stall;

  // Combinational forwarding selects from the current scoreboard
  always_comb begin
    fwd_d_rs = d_src(d_rs, r_e_wa, r_e_tnew, r_m_wa, r_m_tnew, r_w_wa, r_w_tnew);
    fwd_d_rt = d_src(d_rt, r_e_wa, r_e_tnew, r_m_wa, r_m_tnew, r_w_wa, r_w_tnew);
    fwd_e_rs = e_src(r_e_rs, r_m_wa, r_m_tnew, r_w_wa);
    fwd_e_rt = e_src(r_e_rt, r_m_wa, r_m_tnew, r_w_wa);
  end

  // Advance the scoreboard one stage per cycle; a stalled or empty D slot
  // becomes a bubble in E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_wa       <= 5'd0;
      r_e_tnew     <= 4'd0;
      r_e_rs       <= 5'd0;
      r_e_rt       <= 5'd0;
      r_e_md_start <= 1'b0;
      r_m_wa       <= 5'd0;
      r_m_tnew     <= 4'd0;
      r_w_wa       <= 5'd0;
      r_w_tnew     <= 4'd0;
    end else begin
      if (w_issue) begin
        r_e_wa       <= d_wa;
        r_e_tnew     <= sat_dec(d_tnew);
        r_e_rs       <= d_rs;
        r_e_rt       <= d_rt;
        r_e_md_start <= d_md_start;
      end else begin
        r_e_wa       <= 5'd0;
        r_e_tnew     <= 4'd0;
        r_e_rs       <= 5'd0;
        r_e_rt       <= 5'd0;
        r_e_md_start <= 1'b0;
      end
      r_m_wa   <= r_e_wa;
      r_m_tnew <= sat_dec(r_e_tnew);
      r_w_wa   <= r_m_wa;
      r_w_tnew <= sat_dec(r_m_tnew);
    end
  end

  // Mult/div busy window: load on a start in E, then count down to idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt <= 4'd0;
    end else if (r_e_md_start) begin
      r_md_cnt <= L_MD_LAT;
    end else if (r_md_cnt != 4'd0) begin
      r_md_cnt <= r_md_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset/idle, load-use on rs and rt,
// branch-after-ALU, $0 handling, forwarding priority, the mult/div busy
// window and reset landing in the middle of a mult/div stall.
module tb_hazard_ctrl;

  localparam logic [3:0] TMAX = 4'd15;

  // Clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [4:0] d_wa;
  logic [3:0] d_tuse_rs;
  logic [3:0] d_tuse_rt;
  logic [3:0] d_tnew;
  logic       d_md_start;
  logic       d_md_use;
  logic       stall;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;
  logic       md_busy;

  int n_checks;
  int n_errors;

  hazard_ctrl #(.MD_LAT(5), .TMAX(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_wa       (d_wa),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .fwd_d_rs   (fwd_d_rs),
    .fwd_d_rt   (fwd_d_rt),
    .fwd_e_rs   (fwd_e_rs),
    .fwd_e_rt   (fwd_e_rt),
    .md_busy    (md_busy)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] wa, input logic [3:0] tu_rs,
                         input logic [3:0] tu_rt, input logic [3:0] tn,
                         input logic md_s, input logic md_u);
    d_valid    = v;
    d_rs       = rs;
    d_rt       = rt;
    d_wa       = wa;
    d_tuse_rs  = tu_rs;
    d_tuse_rt  = tu_rt;
    d_tnew     = tn;
    d_md_start = md_s;
    d_md_use   = md_u;
    #1;
  endtask

  task automatic bubble();
    drive_d(1'b0, 5'd0, 5'd0, 5'd0, TMAX, TMAX, 4'd0, 1'b0, 1'b0);
  endtask

  // Advance one cycle; inputs are changed 1 time unit after the edge and
  // outputs are sampled after they settle, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    bubble();
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [9:0] all_out;
  assign all_out = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy};

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    bubble();

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      check("in_reset_outputs", 16'(all_out), 16'h0);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("idle_outputs", 16'(all_out), 16'h0);
      tick();
    end

    // Load-use on rs: lw $8 then add rs=$8
    drive_d(1'b1, 5'd1, 5'd2, 5'd8, 4'd1, TMAX, 4'd3, 1'b0, 1'b0);
    check("lu_lw_stall", 16'(stall), 16'h0);
    tick();
    drive_d(1'b1, 5'd8, 5'd3, 5'd10, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
    check("lu_stall_c1", 16'(stall), 16'h1);
    check("lu_fwd_c1", 16'(fwd_d_rs), 16'h0);
    tick();
    check("lu_stall_c2", 16'(stall), 16'h0);
    check("lu_fwd_c2", 16'(fwd_d_rs), 16'h0);
    tick();
    bubble();
    check("lu_fwd_e_rs", 16'(fwd_e_rs), 16'h2);
    check("lu_fwd_e_rt", 16'(fwd_e_rt), 16'h0);
    drain(3);

    // Load-use on rt, with a bubble in D that must not stall
    drive_d(1'b1, 5'd1, 5'd2, 5'd12, 4'd1, TMAX, 4'd3, 1'b0, 1'b0);
    tick();
    drive_d(1'b0, 5'd12, 5'd12, 5'd0, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
    check("rt_bubble_nostall", 16'(stall), 16'h0);
    drive_d(1'b1, 5'd4, 5'd12, 5'd13, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
    check("rt_stall", 16'(stall), 16'h1);
    tick();
    check("rt_release", 16'(stall), 16'h0);
    drain(4);

    // Branch after ALU: add $9 then beq rs=$9 (Tuse 0)
    drive_d(1'b1, 5'd1, 5'd2, 5'd9, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
    tick();
    drive_d(1'b1, 5'd9, 5'd0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    check("br_stall_c1", 16'(stall), 16'h1);
    check("br_fwd_c1", 16'(fwd_d_rs), 16'h0);
    tick();
    check("br_stall_c2", 16'(stall), 16'h0);
    check("br_fwd_c2", 16'(fwd_d_rs), 16'h2);
    check("br_fwd_rt_zero", 16'(fwd_d_rt), 16'h0);
    tick();
    bubble();
    check("br_after_stall", 16'(stall), 16'h0);
    drain(3);

    // $0 never matches
    drive_d(1'b1, 5'd1, 5'd2, 5'd0, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
    tick();
    drive_d(1'b1, 5'd0, 5'd0, 5'd14, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);
    check("zero_stall", 16'(stall), 16'h0);
    check("zero_fwd_e", 16'(fwd_d_rs), 16'h0);
    tick();
    drive_d(1'b1, 5'd0, 5'd0, 5'd0, 4'd1, 4'd1, 4'd0, 1'b0, 1'b0);
    check("zero_fwd_m", 16'({fwd_d_rs, fwd_d_rt}), 16'h0);
    drain(4);

    // Priority: two writers of $5, younger one (E, tnew 0) wins
    drive_d(1'b1, 5'd1, 5'd2, 5'd5, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
    tick();
    drive_d(1'b1, 5'd3, 5'd4, 5'd5, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0);
    check("pri_no_stall1", 16'(stall), 16'h0);
    tick();
    drive_d(1'b1, 5'd5, 5'd5, 5'd0, 4'd1, 4'd1, 4'd0, 1'b0, 1'b0);
    check("pri_no_stall2", 16'(stall), 16'h0);
    check("pri_fwd_d", 16'({fwd_d_rs, fwd_d_rt}), 16'h5);
    tick();
    drive_d(1'b1, 5'd7, 5'd0, 5'd0, 4'd1, 4'd1, 4'd0, 1'b0, 1'b0);
    check("pri_fwd_e_m", 16'({fwd_e_rs, fwd_e_rt}), 16'h5);
    tick();
    drive_d(1'b1, 5'd5, 5'd0, 5'd0, 4'd1, 4'd1, 4'd0, 1'b0, 1'b0);
    check("pri_fwd_d_w", 16'(fwd_d_rs), 16'h3);
    check("pri_fwd_e_w", 16'({fwd_e_rs, fwd_e_rt}), 16'h0);
    drain(4);

    // Mult/div: mult then mflo, 6 stall cycles, 5 busy cycles
    drive_d(1'b1, 5'd1, 5'd2, 5'd0, 4'd1, 4'd1, 4'd0, 1'b1, 1'b1);
    check("md_start_stall", 16'({stall, md_busy}), 16'h0);
    tick();
    drive_d(1'b1, 5'd0, 5'd0, 5'd11, TMAX, TMAX, 4'd2, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("md_stall", 16'(stall), 16'h1);
      check("md_busy", 16'(md_busy), (i > 0) ? 16'h1 : 16'h0);
      check("md_no_reload", 16'(dut.r_e_md_start & md_busy), 16'h0);
      tick();
    end
    check("md_issue", 16'({stall, md_busy}), 16'h0);
    tick();
    bubble();
    check("md_after_issue", 16'({stall, md_busy}), 16'h0);
    drain(2);

    // Reset in the middle of the mult/div stall window
    drive_d(1'b1, 5'd1, 5'd2, 5'd0, 4'd1, 4'd1, 4'd0, 1'b1, 1'b1);
    tick();
    drive_d(1'b1, 5'd0, 5'd0, 5'd11, TMAX, TMAX, 4'd2, 1'b0, 1'b1);
    tick();
    tick();
    check("rst_pre_window", 16'({stall, md_busy}), 16'h3);
    reset = 1'b0;
    #1;
    check("rst_async_drop", 16'({stall, md_busy}), 16'h0);
    tick();
    check("rst_held", 16'(all_out), 16'h0);
    tick();
    reset = 1'b1;
    #1;
    check("rst_release_nostall", 16'({stall, md_busy}), 16'h0);
    tick();
    bubble();
    check("rst_mflo_issued", 16'({stall, md_busy}), 16'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
